// File: rtl/spynet_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : spynet_pkg                                                       |
// | Shared defaults, feeder state encoding and the window tap-slice helper.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package spynet_pkg;

  localparam int c_BITS_DEFAULT   = 16;
  localparam int c_KERNEL_DEFAULT = 7;

  localparam int         c_ST_W      = 2;
  localparam logic [1:0] c_ST_FILL   = 2'd0;
  localparam logic [1:0] c_ST_STREAM = 2'd1;
  localparam logic [1:0] c_ST_FLUSH  = 2'd2;

  // LSB of tap i in a packed window; tap 0 (oldest) sits in the MSB slice.
  function automatic int win_slice(input int i, input int kernel, input int bits);
    return (kernel - 1 - i) * bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_shift_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pixel_shift_reg                                                  |
// | KERNEL x BITS tap shift register with clear/preload-zero and flat output.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pixel_shift_reg
  import spynet_pkg::*;
#(
  parameter int BITS   = c_BITS_DEFAULT,
  parameter int KERNEL = c_KERNEL_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   shift_en_i,
  input  logic [BITS-1:0]        shift_in_i,
  input  logic                   clear_i,
  input  logic                   preload_zero_i,
  output logic [KERNEL*BITS-1:0] win_o,
  output logic [KERNEL*BITS-1:0] win_next_o
);

  logic [KERNEL*BITS-1:0] win_q;
  logic [KERNEL*BITS-1:0] win_d;
  logic [KERNEL*BITS-1:0] w_shifted;

  // Window as it looks after one shift; the top registers this as its output word.
  always_comb begin
    w_shifted = '0;
    for (int i = 0; i < KERNEL - 1; i++) begin
      w_shifted[win_slice(i, KERNEL, BITS) +: BITS] =
        win_q[win_slice(i + 1, KERNEL, BITS) +: BITS];
    end
    w_shifted[win_slice(KERNEL - 1, KERNEL, BITS) +: BITS] = shift_in_i;
  end

  always_comb begin
    win_d = win_q;
    if (clear_i || preload_zero_i) begin
      win_d = '0;
    end else if (shift_en_i) begin
      win_d = w_shifted;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q <= '0;
    end else begin
      win_q <= win_d;
    end
  end

  assign win_o      = win_q;
  assign win_next_o = w_shifted;

endmodule
`default_nettype wire

// File: rtl/kernel_window_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : kernel_window_feeder                                             |
// | Turns a pixel stream into sliding KERNEL-tap windows, one row at a time.   |
// | Optional zero "same" padding: define KERNEL_WINDOW_PAD_EN.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module kernel_window_feeder
  import spynet_pkg::*;
#(
  parameter int BITS      = c_BITS_DEFAULT,
  parameter int KERNEL    = c_KERNEL_DEFAULT,
  parameter int ROW_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [BITS-1:0]        pix_in,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  output logic [KERNEL*BITS-1:0] data_out,
  output logic                   data_valid,
  input  logic                   data_ready,
  output logic                   data_last
);

  localparam int CNT_W  = $clog2(ROW_WIDTH + KERNEL);
  localparam int c_HALF = KERNEL / 2;
`ifdef KERNEL_WINDOW_PAD_EN
  localparam bit c_PAD = 1'b1;
`else
  localparam bit c_PAD = 1'b0;
`endif
  localparam bit         c_FLUSH_EN  = c_PAD && (c_HALF > 0);
  localparam int         c_FILL_N    = c_PAD ? c_HALF : KERNEL - 1;
  localparam logic [1:0] c_ROW_START = (c_FILL_N == 0) ? c_ST_STREAM : c_ST_FILL;

  localparam logic [CNT_W-1:0] c_FILL_LAST  = CNT_W'((c_FILL_N > 0) ? c_FILL_N - 1 : 0);
  localparam logic [CNT_W-1:0] c_LAST_COL   = CNT_W'(ROW_WIDTH - 1);
  localparam logic [CNT_W-1:0] c_LAST_FLUSH = CNT_W'(ROW_WIDTH + c_HALF - 1);
  localparam logic [CNT_W-1:0] c_ONE        = CNT_W'(1);

  logic [c_ST_W-1:0]      state_q, state_d;
  logic [CNT_W-1:0]       col_q, col_d;
  logic [KERNEL*BITS-1:0] data_out_q, data_out_d;
  logic                   data_valid_q, data_valid_d;
  logic                   data_last_q, data_last_d;

  logic                   w_slot;
  logic                   w_accept;
  logic                   w_shift_en;
  logic                   w_row_end;
  logic [BITS-1:0]        w_shift_val;
  logic [KERNEL*BITS-1:0] w_win;
  logic [KERNEL*BITS-1:0] w_win_next;

  // Output slot is free when nothing is held or the held word leaves this cycle.
  assign w_slot    = !data_valid_q || data_ready;
  assign pix_ready = !rst && (state_q != c_ST_FLUSH) && w_slot;
  assign w_accept  = pix_valid && pix_ready;

  pixel_shift_reg #(
    .BITS   (BITS),
    .KERNEL (KERNEL)
  ) u_shift (
    .clk            (clk),
    .rst            (rst),
    .shift_en_i     (w_shift_en),
    .shift_in_i     (w_shift_val),
    .clear_i        (w_row_end && !c_PAD),
    .preload_zero_i (w_row_end && c_PAD),
    .win_o          (w_win),
    .win_next_o     (w_win_next)
  );

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    data_last_d  = data_last_q;
    w_shift_en   = 1'b0;
    w_shift_val  = pix_in;
    w_row_end    = 1'b0;

    if (data_valid_q && data_ready) begin
      data_valid_d = 1'b0;
      data_last_d  = 1'b0;
    end

    case (state_q)
      c_ST_FILL: begin
        if (w_accept) begin
          w_shift_en = 1'b1;
          col_d      = col_q + c_ONE;
          if (col_q == c_FILL_LAST) begin
            state_d = c_ST_STREAM;
          end
        end
      end
      c_ST_STREAM: begin
        if (w_accept) begin
          w_shift_en   = 1'b1;
          data_out_d   = w_win_next;
          data_valid_d = 1'b1;
          data_last_d  = 1'b0;
          col_d        = col_q + c_ONE;
          if (col_q == c_LAST_COL) begin
            if (c_FLUSH_EN) begin
              state_d = c_ST_FLUSH;
            end else begin
              data_last_d = 1'b1;
              w_row_end   = 1'b1;
              col_d       = '0;
              state_d     = c_ROW_START;
            end
          end
        end
      end
      c_ST_FLUSH: begin
        // col keeps counting past the row end to pace the trailing zero taps.
        if (w_slot) begin
          w_shift_en   = 1'b1;
          w_shift_val  = '0;
          data_out_d   = w_win_next;
          data_valid_d = 1'b1;
          data_last_d  = 1'b0;
          col_d        = col_q + c_ONE;
          if (col_q == c_LAST_FLUSH) begin
            data_last_d = 1'b1;
            w_row_end   = 1'b1;
            col_d       = '0;
            state_d     = c_ROW_START;
          end
        end
      end
      default: begin
        w_row_end = 1'b1;
        col_d     = '0;
        state_d   = c_ROW_START;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= c_ROW_START;
      col_q        <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      data_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      data_last_q  <= data_last_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign data_last  = data_last_q;

  logic w_unused;
  assign w_unused = ^w_win;

endmodule
`default_nettype wire

// File: tb/tb_kernel_window_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_kernel_window_feeder                                          |
// | Directed bench for kernel_window_feeder (BITS=16, KERNEL=7, ROW_WIDTH=10). |
// | Padding scenario runs when KERNEL_WINDOW_PAD_EN is defined.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_kernel_window_feeder;

  localparam int BITS = 16;
  localparam int K    = 7;
  localparam int RW   = 10;
  localparam int W    = K * BITS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   pix_in = '0;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic [W-1:0]  data_out;
  logic          data_valid;
  logic          data_ready = 1'b1;
  logic          data_last;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] got_w[$];
  logic         got_l[$];

  kernel_window_feeder #(
    .BITS      (BITS),
    .KERNEL    (K),
    .ROW_WIDTH (RW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .data_last  (data_last)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && data_valid && data_ready) begin
      got_w.push_back(data_out);
      got_l.push_back(data_last);
    end
  end

  function automatic logic [W-1:0] exp_win(input int s);
    logic [W-1:0] r;
    for (int i = 0; i < K; i++) r[(K - 1 - i) * BITS +: BITS] = 16'(s + i);
    return r;
  endfunction

  function automatic logic [W-1:0] exp_pad(input int j);
    logic [W-1:0] r;
    for (int t = 0; t < K; t++) begin
      int p;
      p = j - K / 2 + 1 + t;
      r[(K - 1 - t) * BITS +: BITS] = (p >= 1 && p <= RW) ? 16'(p) : 16'h0;
    end
    return r;
  endfunction

  task automatic send(input int v, input bit gap);
    bit done;
    int guard;
    pix_in = 16'(v); pix_valid = 1'b1; done = 1'b0; guard = 0;
    while (!done && guard < 50) begin
      @(negedge clk);
      done = pix_ready;
      guard++;
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: pixel %0d not accepted within %0d cycles", v, guard);
    end
    if (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    pix_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    pix_valid = 1'b0; data_ready = 1'b1; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    got_w.delete(); got_l.delete();
  endtask

  task automatic check_rows(input string name, input int n, input int first0, input int first1);
    vectors++;
    if (got_w.size() !== n) begin
      miscompares++;
      $display("FAIL %s_count: got %0d windows, expected %0d", name, got_w.size(), n);
    end
    for (int i = 0; i < n; i++) begin
      int s;
      bit last_exp;
      s = (i < 4) ? first0 + i : first1 + i - 4;
      last_exp = (i % 4 == 3);
      vectors++;
      if (i >= got_w.size()) begin
        miscompares++;
        $display("FAIL %s_win%0d: missing, expected %h", name, i, exp_win(s));
      end else if (got_w[i] !== exp_win(s) || got_l[i] !== last_exp) begin
        miscompares++;
        $display("FAIL %s_win%0d: got %h last %b, expected %h last %b",
                 name, i, got_w[i], got_l[i], exp_win(s), last_exp);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (data_valid !== 1'b0 || data_last !== 1'b0 || data_out !== '0 || pix_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: valid %b last %b out %h ready %b, expected 0 0 0 0",
               data_valid, data_last, data_out, pix_ready);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (pix_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: got %b expected 1", pix_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    got_w.delete(); got_l.delete();
    for (int v = 1; v <= 6; v++) send(v, 1'b0);
    vectors++;
    if (data_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stream_fill_quiet: data_valid %b expected 0", data_valid);
    end
    send(7, 1'b0);
    vectors++;
    if (data_valid !== 1'b1 || data_out !== 112'h0001_0002_0003_0004_0005_0006_0007) begin
      miscompares++;
      $display("FAIL stream_first_latency: valid %b out %h, expected 1 %h",
               data_valid, data_out, 112'h0001_0002_0003_0004_0005_0006_0007);
    end
    for (int v = 8; v <= 10; v++) send(v, 1'b0);
    idle(4);
    check_rows("stream", 4, 1, 0);
  endtask

  task automatic test_backpressure();
    got_w.delete(); got_l.delete();
    for (int v = 1; v <= 8; v++) send(v, 1'b0);
    data_ready = 1'b0; pix_in = 16'd9; pix_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (pix_ready !== 1'b0 || data_valid !== 1'b1 || data_out !== exp_win(2)) begin
        miscompares++;
        $display("FAIL stall_hold%0d: ready %b valid %b out %h, expected 0 1 %h",
                 c, pix_ready, data_valid, data_out, exp_win(2));
      end
      @(posedge clk); #1;
    end
    data_ready = 1'b1;
    send(9, 1'b0);
    send(10, 1'b0);
    idle(4);
    check_rows("stall", 4, 1, 0);
  endtask

  task automatic test_two_rows();
    got_w.delete(); got_l.delete();
    for (int v = 1; v <= 20; v++) send(v, 1'b0);
    idle(4);
    check_rows("tworow", 8, 1, 11);
    vectors++;
    if (got_w.size() < 5 || got_w[4] !== 112'h000B_000C_000D_000E_000F_0010_0011) begin
      miscompares++;
      $display("FAIL tworow_row2_first: got %h expected %h",
               (got_w.size() >= 5) ? got_w[4] : '0, 112'h000B_000C_000D_000E_000F_0010_0011);
    end
  endtask

  task automatic test_reset_mid_row();
    got_w.delete(); got_l.delete();
    for (int v = 1; v <= 4; v++) send(v, 1'b0);
    rst = 1'b1;
    #1;
    vectors++;
    if (data_valid !== 1'b0 || data_out !== '0 || pix_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_immediate: valid %b out %h ready %b, expected 0 0 0",
               data_valid, data_out, pix_ready);
    end
    pix_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if (pix_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL midreset_ready: got %b expected 0", pix_ready);
      end
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    rst = 1'b0;
    got_w.delete(); got_l.delete();
    for (int v = 1; v <= 7; v++) send(v, 1'b0);
    idle(4);
    vectors++;
    if (got_w.size() !== 1 || got_w[0] !== exp_win(1) || got_l[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_single: got %0d windows first %h, expected 1 window %h",
               got_w.size(), (got_w.size() > 0) ? got_w[0] : '0, exp_win(1));
    end
  endtask

  task automatic test_toggle_valid();
    do_reset();
    for (int v = 1; v <= 10; v++) send(v, 1'b1);
    idle(4);
    check_rows("toggle", 4, 1, 0);
  endtask

  task automatic test_pad();
    do_reset();
    for (int v = 1; v <= 10; v++) send(v, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vectors++;
      if (pix_ready !== (c == 3)) begin
        miscompares++;
        $display("FAIL pad_flush_ready%0d: got %b expected %b", c, pix_ready, c == 3);
      end
      @(posedge clk); #1;
    end
    idle(4);
    vectors++;
    if (got_w.size() !== RW) begin
      miscompares++;
      $display("FAIL pad_count: got %0d windows, expected %0d", got_w.size(), RW);
    end
    for (int j = 0; j < RW; j++) begin
      vectors++;
      if (j >= got_w.size()) begin
        miscompares++;
        $display("FAIL pad_win%0d: missing, expected %h", j, exp_pad(j));
      end else if (got_w[j] !== exp_pad(j) || got_l[j] !== (j == RW - 1)) begin
        miscompares++;
        $display("FAIL pad_win%0d: got %h last %b, expected %h last %b",
                 j, got_w[j], got_l[j], exp_pad(j), j == RW - 1);
      end
    end
    vectors++;
    if (got_w.size() !== RW || got_w[0] !== 112'h0000_0000_0000_0001_0002_0003_0004 ||
        got_w[RW-1] !== 112'h0007_0008_0009_000A_0000_0000_0000) begin
      miscompares++;
      $display("FAIL pad_edges: first %h last %h",
               (got_w.size() > 0) ? got_w[0] : '0,
               (got_w.size() == RW) ? got_w[RW-1] : '0);
    end
  endtask

  initial begin
    test_reset();
`ifdef KERNEL_WINDOW_PAD_EN
    test_pad();
`else
    test_stream();
    test_backpressure();
    test_two_rows();
    test_reset_mid_row();
    test_toggle_valid();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
